// File: rtl/burst_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : burst_mem_responder_if
//  Description : Burst pmem bus between the cacheline adaptor (master) and
//                the memory-side responder (slave), plus responder status.
//  Revision    : 1.0  initial release
// ============================================================================
interface burst_mem_responder_if;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
    logic        proto_err;
    logic        busy;

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp, proto_err, busy
    );

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp, proto_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : burst_mem_responder
//  Description : Memory-side responder for the burst pmem interface. Serves
//                256-bit lines as 4 x 64-bit beats after a fixed latency from
//                an internal line array; flags protocol violations.
//  Revision    : 1.0  initial release
// ============================================================================
module burst_mem_responder #(
    parameter int    LATENCY   = 10,
    parameter int    IDX_W     = 8,
    parameter string INIT_FILE = ""
) (
    input  wire logic             clk,
    input  wire logic             rst,
    burst_mem_responder_if.slave  bus
);
    localparam int LINES = 1 << IDX_W;
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic               op_wr;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   lat_cnt;
    logic [1:0]         beat;
    logic [255:0]       line_buf;
    logic [63:0]        rdata;
    logic               resp;
    logic               perr;
    logic               busy;

    logic [255:0]       mem [LINES];

    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_load_idx;
    logic [255:0]       w_line;
    logic               w_req_ok;
    logic               w_we;

    // Only the line index bits of the address matter; offset and upper bits alias.
    assign w_idx      = bus.pmem_address[5 +: IDX_W];
    // With zero latency the line is fetched in the accepting cycle, before idx is latched.
    assign w_load_idx = (state == IDLE) ? w_idx : idx;
    assign w_line     = mem[w_load_idx];
    // The initiator must keep exactly the accepted op asserted until the last beat.
    assign w_req_ok   = op_wr ? (bus.pmem_write && !bus.pmem_read)
                              : (bus.pmem_read && !bus.pmem_write);
    // A write beat commits only while the request is still valid.
    assign w_we       = (state == BURST) && op_wr && w_req_ok;

    assign bus.pmem_rdata = rdata;
    assign bus.pmem_resp  = resp;
    assign bus.proto_err  = perr;
    assign bus.busy       = busy;

    // Line array write port: one 64-bit beat per cycle, never reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[idx][{beat, 6'd0} +: 64] <= bus.pmem_wdata;
        end
    end

    // Control FSM with registered strobe, data and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_wr    <= 1'b0;
            idx      <= '0;
            lat_cnt  <= '0;
            beat     <= 2'd0;
            line_buf <= '0;
            rdata    <= '0;
            resp     <= 1'b0;
            perr     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp <= 1'b0;
                    if (bus.pmem_read && bus.pmem_write) begin
                        perr <= 1'b1;
                    end else if (bus.pmem_read || bus.pmem_write) begin
                        op_wr   <= bus.pmem_write;
                        idx     <= w_idx;
                        lat_cnt <= CNT_W'(LATENCY);
                        beat    <= 2'd0;
                        busy    <= 1'b1;
                        if (LATENCY == 0) begin
                            line_buf <= w_line;
                            rdata    <= w_line[63:0];
                            resp     <= 1'b1;
                            state    <= BURST;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!w_req_ok) begin
                        perr  <= 1'b1;
                        state <= DONE;
                    end else if (lat_cnt <= CNT_W'(1)) begin
                        lat_cnt  <= '0;
                        beat     <= 2'd0;
                        line_buf <= w_line;
                        rdata    <= w_line[63:0];
                        resp     <= 1'b1;
                        state    <= BURST;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                BURST: begin
                    if (!w_req_ok) begin
                        perr  <= 1'b1;
                        resp  <= 1'b0;
                        state <= DONE;
                    end else if (beat == 2'd3) begin
                        resp  <= 1'b0;
                        state <= DONE;
                    end else begin
                        beat  <= beat + 2'd1;
                        rdata <= line_buf[{beat + 2'd1, 6'd0} +: 64];
                    end
                end
                DONE: begin
                    resp  <= 1'b0;
                    beat  <= 2'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
